// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store unit: funct3 encodings,
// FSM state type, base byte-strobe patterns and the access legality check.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Illegal funct3 for the direction, or a half/word access off its natural boundary.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic err;
    err = 1'b0;
    case (f3)
      F3_B:    err = 1'b0;
      F3_H:    err = off[0];
      F3_W:    err = (off != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the byte/half lane out of the SRAM word and
// sign- or zero-extends it according to funct3.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension.
  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'b0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'b0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage in front of the byte-lane data SRAM. One request at a
// time; every output is registered.
//
// state | meaning
// IDLE  | ready for a request; errors go straight to RESP
// ISSUE | one cycle driving SRAM address/read/strobes
// WAIT  | SRAM read data valid; align and register the load result
// RESP  | one-cycle response pulse
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int WORD_ADDR_BITS = 14,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [2:0]                req_funct3_i,
  input  logic [31:0]               req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  output logic                      resp_valid_o,
  output logic                      resp_err_o,
  output logic [DATA_WIDTH-1:0]     resp_rdata_o,
  output logic [WORD_ADDR_BITS-1:0] sram_addr_o,
  output logic                      sram_read_o,
  output logic [3:0]                sram_write_o,
  output logic [DATA_WIDTH-1:0]     sram_di_o,
  input  logic [DATA_WIDTH-1:0]     sram_do_i
);

  state_e state_q, state_d;
  logic       we_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  logic                      req_ready_q, req_ready_d;
  logic                      resp_valid_q, resp_valid_d;
  logic                      resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]     resp_rdata_q, resp_rdata_d;
  logic [WORD_ADDR_BITS-1:0] sram_addr_q, sram_addr_d;
  logic                      sram_read_q, sram_read_d;
  logic [3:0]                sram_write_q, sram_write_d;
  logic [DATA_WIDTH-1:0]     sram_di_q, sram_di_d;

  logic                  accept;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] load_data;

  // Address bits above the SRAM range alias and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:WORD_ADDR_BITS+2];

  assign accept  = req_valid_i & req_ready_q;
  assign acc_err = access_err(req_we_i, req_funct3_i, req_addr_i[1:0]);

  mem_load_align u_align (
    .word_i   (sram_do_i),
    .funct3_i (f3_q),
    .off_i    (off_q),
    .data_o   (load_data)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Capture the request fields needed after ISSUE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_q  <= 1'b0;
      f3_q  <= 3'b000;
      off_q <= 2'b00;
    end else if (accept) begin
      we_q  <= req_we_i;
      f3_q  <= req_funct3_i;
      off_q <= req_addr_i[1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = acc_err ? RESP : ISSUE;
      ISSUE:   state_d = we_q ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; the SRAM command is formed from
  // the request as it is accepted so it appears exactly in ISSUE.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = (state_q == IDLE) && (state_d == RESP);
    resp_rdata_d = (state_q == WAIT) ? load_data : '0;
    sram_addr_d  = sram_addr_q;
    sram_read_d  = 1'b0;
    sram_write_d = 4'b0000;
    sram_di_d    = sram_di_q;
    if ((state_q == IDLE) && (state_d == ISSUE)) begin
      sram_addr_d = req_addr_i[WORD_ADDR_BITS+1:2];
      if (req_we_i) begin
        case (req_funct3_i)
          F3_B: begin
            sram_write_d = STRB_B << req_addr_i[1:0];
            sram_di_d    = {4{req_wdata_i[7:0]}};
          end
          F3_H: begin
            sram_write_d = STRB_H << {req_addr_i[1], 1'b0};
            sram_di_d    = {2{req_wdata_i[15:0]}};
          end
          default: begin
            sram_write_d = STRB_W;
            sram_di_d    = req_wdata_i;
          end
        endcase
      end else begin
        sram_read_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      sram_addr_q  <= '0;
      sram_read_q  <= 1'b0;
      sram_write_q <= 4'b0000;
      sram_di_q    <= '0;
    end else begin
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_read_q  <= sram_read_d;
      sram_write_q <= sram_write_d;
      sram_di_q    <= sram_di_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_read_o  = sram_read_q;
  assign sram_write_o = sram_write_q;
  assign sram_di_o    = sram_di_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural byte-lane SRAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [13:0] sram_addr;
  logic        sram_read;
  logic [3:0]  sram_write;
  logic [31:0] sram_di;
  logic [31:0] sram_do = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.WORD_ADDR_BITS(14), .DATA_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_err_o   (resp_err),
    .resp_rdata_o (resp_rdata),
    .sram_addr_o  (sram_addr),
    .sram_read_o  (sram_read),
    .sram_write_o (sram_write),
    .sram_di_o    (sram_di),
    .sram_do_i    (sram_do)
  );

  // Behavioural SRAM: byte-lane writes, registered read data, never reset.
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (sram_write[b]) mem[sram_addr][8*b +: 8] <= sram_di[8*b +: 8];
    if (sram_read) sram_do <= mem[sram_addr];
  end

  int resp_seen = 0;
  always @(posedge clk) if (resp_valid) resp_seen <= resp_seen + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] r_lat, r_rdata, r_err, r_rd, r_wr, r_iaddr, r_istrb, r_idi;

  // Issue one request and observe it until the response (or a cycle budget).
  // r_lat counts cycles after the accept edge: 1 = first cycle after it.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    int k;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("ready_timeout", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    r_lat = 0; r_rdata = 0; r_err = 0; r_rd = 0; r_wr = 0;
    r_iaddr = 0; r_istrb = 0; r_idi = 0;
    for (int i = 1; i <= 8; i++) begin
      if (sram_read) r_rd++;
      if (sram_write != 4'b0000) begin
        r_wr++;
        r_istrb = {28'b0, sram_write};
        r_idi   = sram_di;
      end
      if (sram_read || sram_write != 4'b0000) r_iaddr = {18'b0, sram_addr};
      if (resp_valid) begin
        r_lat   = i;
        r_rdata = resp_rdata;
        r_err   = {31'b0, resp_err};
        break;
      end
      @(negedge clk);
    end
    if (r_lat == 0) check("resp_timeout", {31'b0, resp_valid}, 32'd1);
  endtask

  logic        e_we   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0]  e_f3   [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
  logic [31:0] e_addr [4] = '{32'h11, 32'h22, 32'h0, 32'h0};

  initial begin
    int acc_idx [2];
    int rsp_idx [2];
    logic [31:0] rsp_dat [2];
    int n_acc, n_rsp, snap;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err",   {31'b0, resp_err},   32'd0);
    check("rst_resp_rdata", resp_rdata,          32'd0);
    check("rst_sram_read",  {31'b0, sram_read},  32'd0);
    check("rst_sram_write", {28'b0, sram_write}, 32'd0);
    check("rst_sram_addr",  {18'b0, sram_addr},  32'd0);
    check("rst_sram_di",    sram_di,             32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);

    // sb 0x102
    do_req(1'b1, 3'b000, 32'h0000_0102, 32'h0000_00AB);
    check("sb_addr",  r_iaddr, 32'h40);
    check("sb_strb",  r_istrb, 32'b0100);
    check("sb_di",    r_idi,   32'hABAB_ABAB);
    check("sb_wrcnt", r_wr,    32'd1);
    check("sb_lat",   r_lat,   32'd2);
    check("sb_err",   r_err,   32'd0);
    check("sb_rdata", r_rdata, 32'd0);

    // sw then lw at 0x10
    do_req(1'b1, 3'b010, 32'h10, 32'h1234_5678);
    check("sw_strb", r_istrb, 32'hF);
    check("sw_di",   r_idi,   32'h1234_5678);
    check("sw_lat",  r_lat,   32'd2);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_addr",  r_iaddr, 32'h4);
    check("lw_rdcnt", r_rd,    32'd1);
    check("lw_wrcnt", r_wr,    32'd0);
    check("lw_lat",   r_lat,   32'd3);
    check("lw_rdata", r_rdata, 32'h1234_5678);
    check("lw_err",   r_err,   32'd0);

    // Extension cases on 0x80C07F01 at 0x20
    do_req(1'b1, 3'b010, 32'h20, 32'h80C0_7F01);
    do_req(1'b0, 3'b000, 32'h23, 32'h0);
    check("lb_23",  r_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h23, 32'h0);
    check("lbu_23", r_rdata, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'h22, 32'h0);
    check("lh_22",  r_rdata, 32'hFFFF_80C0);
    do_req(1'b0, 3'b101, 32'h20, 32'h0);
    check("lhu_20", r_rdata, 32'h0000_7F01);
    do_req(1'b0, 3'b000, 32'h21, 32'h0);
    check("lb_21",  r_rdata, 32'h0000_007F);

    // sh into upper half, then read the merged word
    do_req(1'b1, 3'b001, 32'h22, 32'hFFFF_1234);
    check("sh_strb", r_istrb, 32'b1100);
    check("sh_di",   r_idi,   32'h1234_1234);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    check("sh_merge", r_rdata, 32'h1234_7F01);

    // Aliased upper address bits are not an error
    do_req(1'b0, 3'b010, 32'h0001_0010, 32'h0);
    check("alias_err",   r_err,   32'd0);
    check("alias_addr",  r_iaddr, 32'h4);
    check("alias_rdata", r_rdata, 32'h1234_5678);

    // Error cases
    for (int t = 0; t < 4; t++) begin
      do_req(e_we[t], e_f3[t], e_addr[t], 32'hFFFF_FFFF);
      check($sformatf("err%0d_lat", t),   r_lat,         32'd1);
      check($sformatf("err%0d_err", t),   r_err,         32'd1);
      check($sformatf("err%0d_rdata", t), r_rdata,       32'd0);
      check($sformatf("err%0d_sram", t),  r_rd + r_wr,   32'd0);
    end

    // Two loads with req_valid held high
    @(negedge clk);
    acc_idx = '{-100, -100};
    rsp_idx = '{-100, -100};
    rsp_dat = '{32'h0, 32'h0};
    n_acc = 0; n_rsp = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    for (int i = 0; i < 16; i++) begin
      if (req_valid && req_ready && n_acc < 2) begin
        acc_idx[n_acc] = i;
        n_acc++;
      end
      if (resp_valid) begin
        if (n_rsp < 2) begin
          rsp_idx[n_rsp] = i;
          rsp_dat[n_rsp] = resp_rdata;
        end
        n_rsp++;
      end
      if (n_acc == 1 && i == acc_idx[0] + 1) req_addr = 32'h20;
      if (n_acc == 2 && i > acc_idx[1]) req_valid = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_nrsp",   n_rsp,                     32'd2);
    check("b2b_lat1",   rsp_idx[0] - acc_idx[0],   32'd3);
    check("b2b_gap",    acc_idx[1] - rsp_idx[0],   32'd1);
    check("b2b_lat2",   rsp_idx[1] - acc_idx[1],   32'd3);
    check("b2b_data1",  rsp_dat[0],                32'h1234_5678);
    check("b2b_data2",  rsp_dat[1],                32'h1234_7F01);

    // Reset during WAIT of a load
    @(negedge clk);
    snap = resp_seen;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("rstw_noresp", resp_seen - snap, 32'd0);

    // Reset during ISSUE of a store; the SRAM write still lands
    snap = resp_seen;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h30; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rsti_noresp", resp_seen - snap, 32'd0);
    do_req(1'b0, 3'b010, 32'h30, 32'h0);
    check("rsti_rdata", r_rdata, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store stage sitting directly upstream of the 32-bit byte-lane data SRAM (14-bit word address, 4-bit byte write strobes, registered read data with 1-cycle latency). Accepts one byte-addressed load/store request at a time from the core's memory stage. Drives SRAM address, read and strobe lines, replicating store data across byte lanes. Extracts and sign/zero-extends load data and returns a single-cycle response, flagging misaligned or illegal accesses.

Parameters:
WORD_ADDR_BITS, 14, SRAM word-address width; byte address bits [WORD_ADDR_BITS+1:2] select the word.
DATA_WIDTH, 32, fixed data width; other values unsupported.

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  reset, synchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  access type (RISC-V funct3)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle response pulse
resp_err  output  1  valid with resp_valid: misaligned or illegal funct3
resp_rdata  output  32  load result, extended; 0 for stores and errors
sram_addr  output  WORD_ADDR_BITS  to SRAM addr
sram_read  output  1  to SRAM read
sram_write  output  4  to SRAM byte write strobes
sram_di  output  32  to SRAM DI
sram_do  input  32  from SRAM DO

Behaviour:
- All outputs registered. While rst is low at a posedge: state=IDLE; resp_valid, resp_err, sram_read=0; sram_write=0000; resp_rdata, sram_addr, sram_di=0. req_ready=1 in the cycle after reset releases.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. Accept when req_valid&&req_ready; latch we, funct3, addr[1:0], word address, wdata. Error check at accept: error -> RESP with resp_err=1; otherwise -> ISSUE.
- Legal funct3 values: load 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store 000 sb, 001 sh, 010 sw. Any other value is illegal.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]!=00.
- Upper byte-address bits above WORD_ADDR_BITS+1 are ignored (aliasing); they do not cause an error.
- ISSUE lasts one cycle:
  - sram_addr = latched word address.
  - Load: sram_read=1, sram_write=0000.
  - Store: sram_read=0. Strobes are sb: 0001<<addr[1:0]; sh: 0011<<(2*addr[1]); sw: 1111.
  - sram_di is sb: {4{wdata[7:0]}}; sh: {2{wdata[15:0]}}; sw: wdata.
  - Next state: load -> WAIT; store -> RESP.
- WAIT: sram_read=0. sram_do is valid this cycle because the SRAM registered it at the edge ending ISSUE. Select lane by addr[1:0] (byte) or addr[1] (half). Sign-extend for lb/lh, zero-extend for lbu/lhu. Register the result into resp_rdata. Next state -> RESP.
- RESP: resp_valid=1 for exactly one cycle, with resp_err and resp_rdata; req_ready=0. Next state -> IDLE; resp_valid=0 and resp_rdata cleared to 0 in IDLE.
- Latency from accept edge T0 to resp_valid high:
  - error: cycle T0+1, no SRAM activity.
  - store: cycle T0+2.
  - load: cycle T0+3.
  - Back-to-back throughput is one request per 3 (store) or 4 (load) cycles.
- There is no response back-pressure; the consumer must take resp_valid when it is asserted.
- req_valid while busy is ignored, not queued; the requester holds it until req_ready.
- sram_addr holds its last value between accesses; sram_read and sram_write are 0 outside ISSUE.
- Reset mid-operation:
  - Reset sampled at the edge ending ISSUE: the SRAM still commits the store/read at that edge; the unit returns to IDLE and emits no response.
  - Reset in WAIT or RESP: the response is dropped.

Decomposition:
- Package mem_access_pkg:
  - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum IDLE/ISSUE/WAIT/RESP.
  - Strobe constants STRB_B=0001, STRB_H=0011, STRB_W=1111.
- Sub-module mem_load_align: combinational lane select plus extension (inputs word, funct3, addr[1:0]; output 32-bit). Store strobe/replication logic stays inline.

Test Plan:
- sb addr 0x0000_0102, wdata 0x0000_00AB -> in ISSUE cycle: sram_addr=0x0040, sram_write=0100, sram_di=0xABABABAB; resp_valid at T0+2, resp_err=0, resp_rdata=0.
- sw 0x12345678 to 0x10, then lw 0x10 -> sram_read=1 only in ISSUE, sram_addr=0x0004; resp_valid at T0+3 with resp_rdata=0x12345678.
- Word 0x80C0_7F01 stored at 0x20 -> lb 0x23 returns 0xFFFFFF80; lbu 0x23 returns 0x00000080; lh 0x22 returns 0xFFFF80C0; lhu 0x20 returns 0x00007F01.
- lh at 0x11, lw at 0x22, funct3=011, store with funct3=100 -> each gives resp_valid at T0+1 with resp_err=1, resp_rdata=0; no sram_read or sram_write pulse.
- req_valid held high continuously with two loads -> second accepted only in the cycle after resp_valid (req_ready=0 during ISSUE/WAIT/RESP); exactly two responses.
- rst low for one cycle during WAIT of a load -> no resp_valid, req_ready=1 the cycle after rst rises. rst low during ISSUE of sw 0xDEADBEEF at 0x30 -> a later lw 0x30 returns 0xDEADBEEF.
